// File: rtl/digit_sequencer_pkg.sv
// Shared types for the digit sequencer: FSM states, playback modes and direction.
package digit_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LOOP     = 2'b00,
    ONESHOT  = 2'b01,
    PINGPONG = 2'b10
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // The unused encoding 2'b11 plays back as a plain loop.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return ONESHOT;
      2'b10:   return PINGPONG;
      default: return LOOP;
    endcase
  endfunction

endpackage

// File: rtl/digit_sequencer_pattern_ram.sv
// Pattern storage: DEPTH x DIGIT_W register file, synchronous write, combinational read.
module digit_pattern_ram #(
  parameter int DIGIT_W = 4,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DIGIT_W-1:0] rd_data
);

  logic [DIGIT_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/digit_sequencer.sv
// Steps through a stored digit pattern in loop, one-shot or ping-pong order.
//
// state | meaning
// IDLE  | parked at index 0, waiting for start
// RUN   | stepping through the pattern on step_en
// DONE  | one-shot finished, index held on the last entry
module digit_sequencer
  import digit_sequencer_pkg::*;
#(
  parameter  int DIGIT_W = 4,
  parameter  int DEPTH   = 8,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LEN_W   = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic [LEN_W-1:0]   len,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               stop,
  input  logic               step_en,
  output logic [DIGIT_W-1:0] digit,
  output logic [ADDR_W-1:0]  index,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t             state_q, state_n;
  mode_t              mode_q, mode_n;
  dir_t               dir_q, dir_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [ADDR_W-1:0]  index_n;
  logic               done_n, wrap_n;
  logic               at_last;
  logic [DIGIT_W-1:0] rd_data;

  // Reads pre-edge contents, so a write to the displayed entry shows one cycle later.
  digit_pattern_ram #(
    .DIGIT_W (DIGIT_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (index_n),
    .rd_data (rd_data)
  );

  assign at_last = (LEN_W'(index) == (len_q - LEN_W'(1)));
  assign busy    = (state_q == RUN);

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    dir_n   = dir_q;
    len_n   = len_q;
    index_n = index;
    done_n  = 1'b0;
    wrap_n  = 1'b0;

    if (stop) begin
      state_n = IDLE;
      index_n = '0;
      dir_n   = DIR_UP;
    end else if (start) begin
      if (len == '0)               len_n = LEN_W'(1);
      else if (int'(len) > DEPTH)  len_n = LEN_W'(DEPTH);
      else                         len_n = len;
      mode_n  = decode_mode(mode);
      index_n = '0;
      dir_n   = DIR_UP;
      state_n = RUN;
    end else if ((state_q == RUN) && step_en) begin
      case (mode_q)
        ONESHOT: begin
          if (at_last) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            index_n = index + ADDR_W'(1);
          end
        end
        PINGPONG: begin
          // A single-entry pattern has nowhere to bounce; each step is a full cycle.
          if (len_q == LEN_W'(1)) begin
            wrap_n = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (at_last) begin
              dir_n   = DIR_DOWN;
              index_n = index - ADDR_W'(1);
            end else begin
              index_n = index + ADDR_W'(1);
            end
          end else begin
            if (index != '0) begin
              index_n = index - ADDR_W'(1);
            end else begin
              dir_n   = DIR_UP;
              index_n = index + ADDR_W'(1);
              wrap_n  = 1'b1;
            end
          end
        end
        default: begin
          if (at_last) begin
            index_n = '0;
            wrap_n  = 1'b1;
          end else begin
            index_n = index + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= LOOP;
      dir_q   <= DIR_UP;
      len_q   <= LEN_W'(1);
      index   <= '0;
      digit   <= '0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      dir_q   <= dir_n;
      len_q   <= len_n;
      index   <= index_n;
      digit   <= rd_data;
      done    <= done_n;
      wrap    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer with hand-computed expected values.
module tb_digit_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] len = '0;
  logic [1:0] mode = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step_en = 1'b0;
  logic [3:0] digit;
  logic [2:0] index;
  logic       busy, done, wrap;

  int n_checks = 0;
  int n_errors = 0;
  int pat [8] = '{2, 0, 0, 1, 0, 1, 2, 3};
  int pp4_idx [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
  int pp4_wrap [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int pp2_idx [4]  = '{1, 0, 1, 0};
  int pp2_wrap [4] = '{0, 0, 1, 0};

  digit_sequencer dut (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .step_en (step_en),
    .digit   (digit),
    .index   (index),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int idx, input int dig,
                           input int bsy, input int dn, input int wr);
    check({tag, " index"}, 32'(index), idx);
    check({tag, " digit"}, 32'(digit), dig);
    check({tag, " busy"},  32'(busy),  bsy);
    check({tag, " done"},  32'(done),  dn);
    check({tag, " wrap"},  32'(wrap),  wr);
  endtask

  task automatic start_seq(input int l, input int m);
    start = 1'b1;
    len   = 4'(l);
    mode  = 2'(m);
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check_out("reset", 0, 0, 0, 0, 0);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 4'(pat[i]);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check_out("idle loaded", 0, pat[0], 0, 0, 0);

    // loop, len 8
    start_seq(8, 0);
    check_out("loop start", 0, pat[0], 1, 0, 0);
    step_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_out("loop step", k % 8, pat[k % 8], 1, 0, (k % 8 == 0) ? 1 : 0);
    end
    step_en = 1'b0;

    // one-shot, len 5; step_en on the start cycle is ignored
    step_en = 1'b1;
    start_seq(5, 1);
    check_out("oneshot start", 0, pat[0], 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_out("oneshot step", k, pat[k], 1, 0, 0);
    end
    tick();
    check_out("oneshot done", 4, pat[4], 0, 1, 0);
    tick();
    check_out("oneshot held", 4, pat[4], 0, 0, 0);
    step_en = 1'b0;

    // ping-pong, len 4
    start_seq(4, 2);
    step_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("pp4 step", pp4_idx[k], pat[pp4_idx[k]], 1, 0, pp4_wrap[k]);
    end
    step_en = 1'b0;
    tick();
    check_out("pp4 hold", 2, pat[2], 1, 0, 0);

    // ping-pong, len 2
    start_seq(2, 2);
    step_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out("pp2 step", pp2_idx[k], pat[pp2_idx[k]], 1, 0, pp2_wrap[k]);
    end
    step_en = 1'b0;

    // len 0 behaves as len 1
    start_seq(0, 0);
    step_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("len0 loop", 0, pat[0], 1, 0, 1);
    end
    step_en = 1'b0;
    start_seq(0, 2);
    step_en = 1'b1;
    tick();
    check_out("len0 pp", 0, pat[0], 1, 0, 1);
    step_en = 1'b0;
    start_seq(0, 1);
    step_en = 1'b1;
    tick();
    check_out("len0 oneshot", 0, pat[0], 0, 1, 0);
    step_en = 1'b0;

    // len 12 clamps to 8
    start_seq(12, 0);
    step_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_out("len12 loop", k % 8, pat[k % 8], 1, 0, (k == 8) ? 1 : 0);
    end
    step_en = 1'b0;

    // mode 11 plays as loop
    start_seq(3, 3);
    step_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_out("mode3 loop", k % 3, pat[k % 3], 1, 0, (k == 3) ? 1 : 0);
    end
    step_en = 1'b0;

    // write the displayed entry, then stop+start together
    start_seq(8, 0);
    step_en = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    step_en = 1'b0;
    check_out("at idx3", 3, pat[3], 1, 0, 0);
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 4'd9;
    tick();
    wr_en = 1'b0;
    check_out("write edge", 3, pat[3], 1, 0, 0);
    pat[3] = 9;
    tick();
    check_out("write shown", 3, 9, 1, 0, 0);
    stop  = 1'b1;
    start = 1'b1;
    len   = 4'd8;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check_out("stop+start", 0, pat[0], 0, 0, 0);
    step_en = 1'b1;
    tick();
    check_out("idle no step", 0, pat[0], 0, 0, 0);
    step_en = 1'b0;

    // reset mid-run at index 5
    start_seq(8, 0);
    step_en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_out("pre reset", 5, pat[5], 1, 0, 0);
    RST = 1'b1;
    tick();
    check_out("mid reset", 0, 0, 0, 0, 0);
    RST = 1'b0;
    step_en = 1'b0;
    tick();
    check_out("after reset", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
